id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  Instruction-decode stage, directly upstream of the general register file. It accepts
//  {pc,inst} from IF, drives the register file's two read addresses, and captures the
//  operands into the ID/EX pipeline register with a valid/ready handshake. It detects
//  load-use hazards against EX and stalls IF. Flush squashes the stage on branch redirect.
// PARAMETERS
//  INST_WIDTH     32  instruction / PC width
//  REG_ADD_WIDTH  5   register address width (32 GPRs)
//  REG_DAT_WIDTH  32  register data width
// PORTS
//  clk_i            in   1    clock
//  rst_n_i          in   1    asynchronous reset, active-low
//  flush_i          in   1    squash ID/EX register contents and discard the IF beat
//  if_valid_i       in   1    IF beat valid
//  if_ready_o       out  1    ID accepts the IF beat
//  if_pc_i          in   32   PC of the IF beat
//  if_inst_i        in   32   instruction of the IF beat
//  gpr_rd_addr_0_o  out  5    register file read address 0 (= inst[25:21], rs)
//  gpr_rd_data_0_i  in   32   register file read data 0 (write-through bypassed, combinational)
//  gpr_rd_addr_1_o  out  5    register file read address 1 (= inst[20:16], rt)
//  gpr_rd_data_1_i  in   32   register file read data 1
//  ex_load_i        in   1    instruction in EX is a load
//  ex_dst_addr_i    in   5    destination register of the instruction in EX
//  id_valid_o       out  1    ID/EX register holds a valid beat
//  id_ready_i       in   1    EX accepts the beat
//  id_pc_o          out  32   registered PC
//  id_op_o          out  6    registered opcode inst[31:26]
//  id_src0_o        out  32   registered rs value
//  id_src1_o        out  32   registered rt value
//  id_imm_o         out  32   registered sign-extended inst[15:0]
//  id_dst_addr_o    out  5    registered destination register
//  id_wre_o         out  1    registered writeback enable
//  stall_cnt_o      out  16   saturating count of load-use stall cycles
// BEHAVIOUR
//  - Reset: every output register is 0, including id_valid_o, stall_cnt_o, and all id_* outputs.
//  - gpr_rd_addr_*_o are combinational from if_inst_i, regardless of if_valid_i.
//  - Decode: op 6'h00 (R-type): dst = rd inst[15:11], uses rt, wre = 1.
//    op 6'h2B (store) and op 6'h04 (beq): uses rt, wre = 0. All other opcodes: dst = rt, rt unused, wre = 1.
//    dst = 0 forces wre = 0.
//  - stall = if_valid_i & ex_load_i & (ex_dst_addr_i != 0) &
//    (ex_dst_addr_i == rs | (uses_rt & ex_dst_addr_i == rt)).
//  - if_ready_o = (!id_valid_o | id_ready_i) & !stall & !flush_i.
//  - Capture (latency 1): when if_valid_i & if_ready_o, all id_* outputs load the next cycle
//    and id_valid_o = 1.
//  - Drain: when id_valid_o & id_ready_i and there is no capture, id_valid_o = 0 next cycle.
//  - Stall: if EX is ready, id_valid_o drops to 0, inserting a bubble. The IF beat is held
//    upstream. stall_cnt_o += 1 per stall cycle and saturates at 16'hFFFF.
//  - Backpressure: when id_valid_o & !id_ready_i, all id_* outputs hold stable. No new beat is
//    accepted.
//  - flush_i has priority over capture and stall. The next cycle id_valid_o = 0. Payload
//    registers hold. No stall_cnt_o increment.
//  - Reset asserted mid-operation clears all state asynchronously. The first beat after release
//    is accepted normally.
// CONFIGURATION
//  ID_LOAD_USE_STALL_EN
//   defined:   hazard detection and stall_cnt_o behave as above.
//   undefined: stall is tied to 0 and stall_cnt_o is tied to 0. EX must resolve load-use itself.
// TESTING
//  1. Reset, then R-type inst 32'h00221820 (add r3,r1,r2), r1 = 5, r2 = 7, EX ready
//     -> next cycle: id_valid_o = 1, src0 = 5, src1 = 7, dst = 3, wre = 1.
//  2. ex_load_i = 1, ex_dst_addr_i = 1, same add -> if_ready_o = 0 for 1 cycle, id_valid_o = 0,
//     stall_cnt_o = 1. Drop ex_load_i -> beat captured.
//  3. Load to r0 in EX (ex_dst_addr_i = 0) -> no stall. Addi to r0 (op 6'h08, rt = 0) -> wre = 0.
//  4. id_ready_i = 0 for 3 cycles with a valid beat -> id_* outputs stable, if_ready_o = 0.
//     Release -> next beat accepted.
//  5. flush_i together with a valid IF beat -> id_valid_o = 0 next cycle, if_ready_o = 0
//     that cycle.
//  6. Reset pulse while id_valid_o = 1 and stall_cnt_o = 9 -> id_valid_o = 0 and
//     stall_cnt_o = 0 immediately.
//     With ID_LOAD_USE_STALL_EN undefined, re-run scenario 2 -> no stall.

Source files
------------

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage: GPR read addressing, ID/EX register, load-use stall, flush
// Optional feature: define ID_LOAD_USE_STALL_EN to enable load-use hazard detection and stall_cnt_o.
module id_stage #(
    parameter int INST_WIDTH    = 32,
    parameter int REG_ADD_WIDTH = 5,
    parameter int REG_DAT_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    output logic                     if_ready_o,
    input  logic [INST_WIDTH-1:0]    if_pc_i,
    input  logic [INST_WIDTH-1:0]    if_inst_i,
    output logic [REG_ADD_WIDTH-1:0] gpr_rd_addr_0_o,
    input  logic [REG_DAT_WIDTH-1:0] gpr_rd_data_0_i,
    output logic [REG_ADD_WIDTH-1:0] gpr_rd_addr_1_o,
    input  logic [REG_DAT_WIDTH-1:0] gpr_rd_data_1_i,
    input  logic                     ex_load_i,
    input  logic [REG_ADD_WIDTH-1:0] ex_dst_addr_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [INST_WIDTH-1:0]    id_pc_o,
    output logic [5:0]               id_op_o,
    output logic [REG_DAT_WIDTH-1:0] id_src0_o,
    output logic [REG_DAT_WIDTH-1:0] id_src1_o,
    output logic [REG_DAT_WIDTH-1:0] id_imm_o,
    output logic [REG_ADD_WIDTH-1:0] id_dst_addr_o,
    output logic                     id_wre_o,
    output logic [15:0]              stall_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_STORE = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [5:0]               op;
    logic [REG_ADD_WIDTH-1:0] rs;
    logic [REG_ADD_WIDTH-1:0] rt;
    logic [REG_ADD_WIDTH-1:0] rd;
    logic [REG_ADD_WIDTH-1:0] dst;
    logic [REG_DAT_WIDTH-1:0] imm;
    logic                     is_rtype;
    logic                     no_wb;
    logic                     uses_rt;
    logic                     wre;
    logic                     stall;
    logic                     capture;

    assign op  = if_inst_i[31:26];
    assign rs  = if_inst_i[21 +: REG_ADD_WIDTH];
    assign rt  = if_inst_i[16 +: REG_ADD_WIDTH];
    assign rd  = if_inst_i[11 +: REG_ADD_WIDTH];
    assign imm = {{(REG_DAT_WIDTH-16){if_inst_i[15]}}, if_inst_i[15:0]};

    assign gpr_rd_addr_0_o = rs;
    assign gpr_rd_addr_1_o = rt;

    assign is_rtype = (op == OP_RTYPE);
    assign no_wb    = (op == OP_STORE) || (op == OP_BEQ);
    assign uses_rt  = is_rtype || no_wb;
    assign dst      = is_rtype ? rd : rt;
    // Writes to r0 are architecturally void, so never advertise a writeback for them.
    assign wre      = !no_wb && (dst != '0);

`ifdef ID_LOAD_USE_STALL_EN
    assign stall = if_valid_i && ex_load_i && (ex_dst_addr_i != '0) &&
                   ((ex_dst_addr_i == rs) || (uses_rt && (ex_dst_addr_i == rt)));

    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (stall && !flush_i && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_hazard_inputs;

    assign unused_hazard_inputs = ^{ex_load_i, ex_dst_addr_i, uses_rt};
    assign stall       = 1'b0;
    assign stall_cnt_o = '0;
`endif

    assign if_ready_o = (!id_valid_o || id_ready_i) && !stall && !flush_i;
    assign capture    = if_valid_i && if_ready_o;

    // Flush wins; otherwise a capture refills, and a consumed beat with nothing behind it drains.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            id_valid_o <= 1'b0;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
        end else if (capture) begin
            id_valid_o <= 1'b1;
        end else if (id_ready_i) begin
            id_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            id_pc_o       <= '0;
            id_op_o       <= '0;
            id_src0_o     <= '0;
            id_src1_o     <= '0;
            id_imm_o      <= '0;
            id_dst_addr_o <= '0;
            id_wre_o      <= 1'b0;
        end else if (capture) begin
            id_pc_o       <= if_pc_i;
            id_op_o       <= op;
            id_src0_o     <= gpr_rd_data_0_i;
            id_src1_o     <= gpr_rd_data_1_i;
            id_imm_o      <= imm;
            id_dst_addr_o <= dst;
            id_wre_o      <= wre;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - table-driven directed bench for id_stage, with hand-written stall and reset sequences
module tb_id_stage;

`ifdef ID_LOAD_USE_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_ADDI = 32'h20800005;
    localparam logic [31:0] I_SW   = 32'hACA6FFFC;
    localparam logic [31:0] I_BEQ  = 32'h10220010;
    localparam logic [31:0] I_ORI  = 32'h34E88000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic [4:0]  gpr_rd_addr_0_o;
    logic [31:0] gpr_rd_data_0_i;
    logic [4:0]  gpr_rd_addr_1_o;
    logic [31:0] gpr_rd_data_1_i;
    logic        ex_load_i;
    logic [4:0]  ex_dst_addr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [5:0]  id_op_o;
    logic [31:0] id_src0_o;
    logic [31:0] id_src1_o;
    logic [31:0] id_imm_o;
    logic [4:0]  id_dst_addr_o;
    logic        id_wre_o;
    logic [15:0] stall_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    id_stage dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .flush_i         (flush_i),
        .if_valid_i      (if_valid_i),
        .if_ready_o      (if_ready_o),
        .if_pc_i         (if_pc_i),
        .if_inst_i       (if_inst_i),
        .gpr_rd_addr_0_o (gpr_rd_addr_0_o),
        .gpr_rd_data_0_i (gpr_rd_data_0_i),
        .gpr_rd_addr_1_o (gpr_rd_addr_1_o),
        .gpr_rd_data_1_i (gpr_rd_data_1_i),
        .ex_load_i       (ex_load_i),
        .ex_dst_addr_i   (ex_dst_addr_i),
        .id_valid_o      (id_valid_o),
        .id_ready_i      (id_ready_i),
        .id_pc_o         (id_pc_o),
        .id_op_o         (id_op_o),
        .id_src0_o       (id_src0_o),
        .id_src1_o       (id_src1_o),
        .id_imm_o        (id_imm_o),
        .id_dst_addr_o   (id_dst_addr_o),
        .id_wre_o        (id_wre_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file contents: r0=0, r1=5, r2=7, others 0x1000+n.
    function automatic logic [31:0] reg_val(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (a == 5'd1) return 32'd5;
        if (a == 5'd2) return 32'd7;
        return 32'h1000 + {27'd0, a};
    endfunction

    assign gpr_rd_data_0_i = reg_val(gpr_rd_addr_0_o);
    assign gpr_rd_data_1_i = reg_val(gpr_rd_addr_1_o);

    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exl;
        logic [4:0]  exd;
        logic        rdy;
        logic        e_ifr;
        logic        e_val;
        logic [31:0] e_pc;
        logic [5:0]  e_op;
        logic [31:0] e_s0;
        logic [31:0] e_s1;
        logic [31:0] e_imm;
        logic [4:0]  e_dst;
        logic        e_wre;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input logic fl, input logic v, input logic [31:0] pc,
                                input logic [31:0] inst, input logic exl, input logic [4:0] exd,
                                input logic rdy, input logic e_ifr, input logic e_val,
                                input logic [31:0] e_pc, input logic [5:0] e_op,
                                input logic [31:0] e_s0, input logic [31:0] e_s1,
                                input logic [31:0] e_imm, input logic [4:0] e_dst,
                                input logic e_wre);
        vec_t r;
        r.fl = fl; r.v = v; r.pc = pc; r.inst = inst; r.exl = exl; r.exd = exd; r.rdy = rdy;
        r.e_ifr = e_ifr; r.e_val = e_val; r.e_pc = e_pc; r.e_op = e_op; r.e_s0 = e_s0;
        r.e_s1 = e_s1; r.e_imm = e_imm; r.e_dst = e_dst; r.e_wre = e_wre;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input logic [31:0] pc,
                         input logic [31:0] inst, input logic exl, input logic [4:0] exd,
                         input logic rdy);
        flush_i = fl; if_valid_i = v; if_pc_i = pc; if_inst_i = inst;
        ex_load_i = exl; ex_dst_addr_i = exd; id_ready_i = rdy;
    endtask

    initial begin
        rst_n_i = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);

        tbl[0]  = mk(0,1,32'h100,I_ADD, 0,5'd0,1, 1,1,32'h100,6'h00,32'd5,   32'd7,   32'h00001820,5'd3,1);
        tbl[1]  = mk(0,1,32'h104,I_ADDI,1,5'd0,1, 1,1,32'h104,6'h08,32'h1004,32'd0,   32'h00000005,5'd0,0);
        tbl[2]  = mk(0,1,32'h108,I_SW,  0,5'd0,0, 0,1,32'h104,6'h08,32'h1004,32'd0,   32'h00000005,5'd0,0);
        tbl[3]  = tbl[2];
        tbl[4]  = tbl[2];
        tbl[5]  = mk(0,1,32'h108,I_SW,  0,5'd0,1, 1,1,32'h108,6'h2B,32'h1005,32'h1006,32'hFFFFFFFC,5'd6,0);
        tbl[6]  = mk(0,0,32'h10C,I_BEQ, 0,5'd0,1, 1,0,32'h108,6'h2B,32'h1005,32'h1006,32'hFFFFFFFC,5'd6,0);
        tbl[7]  = mk(0,1,32'h10C,I_BEQ, 0,5'd0,0, 1,1,32'h10C,6'h04,32'd5,   32'd7,   32'h00000010,5'd2,0);
        tbl[8]  = mk(1,1,32'h110,I_ORI, 0,5'd0,1, 0,0,32'h10C,6'h04,32'd5,   32'd7,   32'h00000010,5'd2,0);
        tbl[9]  = mk(0,1,32'h110,I_ORI, 0,5'd0,0, 1,1,32'h110,6'h0D,32'h1007,32'h1008,32'hFFFF8000,5'd8,1);
        tbl[10] = mk(0,1,32'h114,I_ADD, 1,5'd9,1, 1,1,32'h114,6'h00,32'd5,   32'd7,   32'h00001820,5'd3,1);
        tbl[11] = mk(0,1,32'h118,I_ORI, 1,5'd8,1, 1,1,32'h118,6'h0D,32'h1007,32'h1008,32'hFFFF8000,5'd8,1);

        repeat (2) @(negedge clk_i);
        #1;
        check("reset_valid", {31'd0, id_valid_o}, 32'd0);
        check("reset_pc", id_pc_o, 32'd0);
        check("reset_payload", {id_op_o, id_dst_addr_o, id_wre_o} | id_src0_o | id_src1_o | id_imm_o, 32'd0);
        check("reset_cnt", {16'd0, stall_cnt_o}, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].fl, tbl[i].v, tbl[i].pc, tbl[i].inst, tbl[i].exl, tbl[i].exd, tbl[i].rdy);
            #1;
            check($sformatf("v%0d_if_ready", i), {31'd0, if_ready_o}, {31'd0, tbl[i].e_ifr});
            check($sformatf("v%0d_rd_addr0", i), {27'd0, gpr_rd_addr_0_o}, {27'd0, tbl[i].inst[25:21]});
            check($sformatf("v%0d_rd_addr1", i), {27'd0, gpr_rd_addr_1_o}, {27'd0, tbl[i].inst[20:16]});
            @(posedge clk_i);
            #1;
            check($sformatf("v%0d_valid", i), {31'd0, id_valid_o}, {31'd0, tbl[i].e_val});
            check($sformatf("v%0d_pc", i), id_pc_o, tbl[i].e_pc);
            check($sformatf("v%0d_op", i), {26'd0, id_op_o}, {26'd0, tbl[i].e_op});
            check($sformatf("v%0d_src0", i), id_src0_o, tbl[i].e_s0);
            check($sformatf("v%0d_src1", i), id_src1_o, tbl[i].e_s1);
            check($sformatf("v%0d_imm", i), id_imm_o, tbl[i].e_imm);
            check($sformatf("v%0d_dst", i), {27'd0, id_dst_addr_o}, {27'd0, tbl[i].e_dst});
            check($sformatf("v%0d_wre", i), {31'd0, id_wre_o}, {31'd0, tbl[i].e_wre});
            check($sformatf("v%0d_cnt", i), {16'd0, stall_cnt_o}, 32'd0);
            @(negedge clk_i);
        end

        // Load-use on rs, then on rt, then hazard clears.
        drive(0, 1, 32'h200, I_ADD, 1, 5'd1, 1);
        #1;
        check("lu_rs_if_ready", {31'd0, if_ready_o}, {31'd0, !STALL_EN});
        @(posedge clk_i); #1;
        check("lu_rs_valid", {31'd0, id_valid_o}, {31'd0, !STALL_EN});
        check("lu_rs_cnt", {16'd0, stall_cnt_o}, STALL_EN ? 32'd1 : 32'd0);
        @(negedge clk_i);
        drive(0, 1, 32'h204, I_ADD, 1, 5'd2, 1);
        #1;
        check("lu_rt_if_ready", {31'd0, if_ready_o}, {31'd0, !STALL_EN});
        @(posedge clk_i); #1;
        check("lu_rt_valid", {31'd0, id_valid_o}, {31'd0, !STALL_EN});
        check("lu_rt_cnt", {16'd0, stall_cnt_o}, STALL_EN ? 32'd2 : 32'd0);
        @(negedge clk_i);
        drive(0, 1, 32'h208, I_ADD, 0, 5'd1, 1);
        #1;
        check("lu_clear_if_ready", {31'd0, if_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        check("lu_clear_valid", {31'd0, id_valid_o}, 32'd1);
        check("lu_clear_pc", id_pc_o, 32'h208);
        check("lu_clear_src0", id_src0_o, 32'd5);

        // Stall under backpressure keeps the beat and counts up to 9, then async reset.
        @(negedge clk_i);
        drive(0, 1, 32'h20C, I_ADD, 1, 5'd1, 0);
        repeat (7) @(negedge clk_i);
        #1;
        check("bp_if_ready", {31'd0, if_ready_o}, 32'd0);
        check("bp_valid", {31'd0, id_valid_o}, 32'd1);
        check("bp_pc", id_pc_o, 32'h208);
        check("bp_cnt", {16'd0, stall_cnt_o}, STALL_EN ? 32'd9 : 32'd0);
        #1;
        rst_n_i = 1'b0;
        #1;
        check("arst_valid", {31'd0, id_valid_o}, 32'd0);
        check("arst_cnt", {16'd0, stall_cnt_o}, 32'd0);
        check("arst_pc", id_pc_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        drive(0, 1, 32'h300, I_ADD, 0, 5'd0, 1);
        #1;
        check("post_rst_if_ready", {31'd0, if_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        check("post_rst_valid", {31'd0, id_valid_o}, 32'd1);
        check("post_rst_pc", id_pc_o, 32'h300);
        check("post_rst_src1", id_src1_o, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
